cv32e40p_xif_mem_arbiter: RTL

//  Shares the single OBI data port between the core LSU and the CORE-V-XIF memory

---
 rtl/cv32e40p_xif_mem_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_xif_mem_arbiter.sv
// Round-robin arbiter sharing the OBI data port between the core LSU and a CORE-V-XIF
// memory interface; optional stall counters under CV32E40P_XMEM_ARB_STATS_EN.
module cv32e40p_xif_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_WIDTH        = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                core_req_i,
    output logic                core_gnt_o,
    output logic                core_rvalid_o,
    input  logic                core_we_i,
    input  logic [3:0]          core_be_i,
    input  logic [31:0]         core_addr_i,
    input  logic [31:0]         core_wdata_i,
    output logic [31:0]         core_rdata_o,

    input  logic                xmem_valid_i,
    output logic                xmem_ready_o,
    input  logic                xmem_we_i,
    input  logic [3:0]          xmem_be_i,
    input  logic [31:0]         xmem_addr_i,
    input  logic [31:0]         xmem_wdata_i,
    input  logic [ID_WIDTH-1:0] xmem_id_i,
    output logic                xmem_result_valid_o,
    output logic [31:0]         xmem_result_rdata_o,
    output logic [ID_WIDTH-1:0] xmem_result_id_o,

    output logic                data_req_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_addr_o,
    output logic [31:0]         data_wdata_o,
    input  logic [31:0]         data_rdata_i,

    output logic [31:0]         conflict_core_o,
    output logic [31:0]         conflict_xif_o
);

    typedef enum logic {SrcCore = 1'b0, SrcXif = 1'b1} src_e;

    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

    src_e                r_rr_last;
    src_e                r_lock_src;
    logic                r_lock;
    src_e                r_fifo_src [MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0] r_fifo_id  [MAX_OUTSTANDING];
    logic [PtrW-1:0]     r_wptr;
    logic [PtrW-1:0]     r_rptr;
    logic [CntW-1:0]     r_count;

    src_e                w_sel;
    src_e                w_head_src;
    logic                w_sel_req;
    logic                w_full;
    logic                w_accept;
    logic                w_pop;

    // A granted-pending request stays selected until it is accepted.
    always_comb begin
        w_sel = SrcCore;
        if (r_lock) begin
            w_sel = r_lock_src;
        end else if (core_req_i && xmem_valid_i) begin
            w_sel = (r_rr_last == SrcXif) ? SrcCore : SrcXif;
        end else if (xmem_valid_i) begin
            w_sel = SrcXif;
        end
    end

    assign w_full       = (r_count == MaxCnt);
    assign w_sel_req    = (w_sel == SrcCore) ? core_req_i : xmem_valid_i;
    assign data_req_o   = w_sel_req & ~w_full;
    assign w_accept     = data_req_o & data_gnt_i;
    assign core_gnt_o   = w_accept & (w_sel == SrcCore);
    assign xmem_ready_o = w_accept & (w_sel == SrcXif);

    always_comb begin
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (data_req_o) begin
            if (w_sel == SrcCore) begin
                data_we_o    = core_we_i;
                data_be_o    = core_be_i;
                data_addr_o  = core_addr_i;
                data_wdata_o = core_wdata_i;
            end else begin
                data_we_o    = xmem_we_i;
                data_be_o    = xmem_be_i;
                data_addr_o  = xmem_addr_i;
                data_wdata_o = xmem_wdata_i;
            end
        end
    end

    // Responses come back in order; stray rvalid with nothing outstanding is dropped.
    assign w_pop      = data_rvalid_i & (r_count != '0);
    assign w_head_src = r_fifo_src[r_rptr];

    assign core_rvalid_o       = w_pop & (w_head_src == SrcCore);
    assign core_rdata_o        = core_rvalid_o ? data_rdata_i : '0;
    assign xmem_result_valid_o = w_pop & (w_head_src == SrcXif);
    assign xmem_result_rdata_o = xmem_result_valid_o ? data_rdata_i : '0;
    assign xmem_result_id_o    = xmem_result_valid_o ? r_fifo_id[r_rptr] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock     <= 1'b0;
            r_lock_src <= SrcCore;
            r_rr_last  <= SrcXif;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                r_fifo_src[i] <= SrcCore;
                r_fifo_id[i]  <= '0;
            end
        end else begin
            r_lock <= data_req_o & ~data_gnt_i;
            if (data_req_o) begin
                r_lock_src <= w_sel;
            end
            if (w_accept) begin
                r_rr_last          <= w_sel;
                r_fifo_src[r_wptr] <= w_sel;
                r_fifo_id[r_wptr]  <= (w_sel == SrcXif) ? xmem_id_i : '0;
                r_wptr             <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CV32E40P_XMEM_ARB_STATS_EN
    logic [31:0] r_conflict_core;
    logic [31:0] r_conflict_xif;
    logic        w_core_blocked;
    logic        w_xif_blocked;

    assign w_core_blocked = core_req_i & (w_sel == SrcXif);
    assign w_xif_blocked  = xmem_valid_i & (w_sel == SrcCore);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conflict_core <= '0;
            r_conflict_xif  <= '0;
        end else begin
            if (w_core_blocked && (r_conflict_core != '1)) begin
                r_conflict_core <= r_conflict_core + 1'b1;
            end
            if (w_xif_blocked && (r_conflict_xif != '1)) begin
                r_conflict_xif <= r_conflict_xif + 1'b1;
            end
        end
    end

    assign conflict_core_o = r_conflict_core;
    assign conflict_xif_o  = r_conflict_xif;
`else
    assign conflict_core_o = 32'h0;
    assign conflict_xif_o  = 32'h0;
`endif

    a_rvalid_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) data_rvalid_i |-> (r_count != '0)
    ) else $warning("data_rvalid_i with no outstanding transaction");

endmodule
